// File: rtl/nes_mem_pkg.sv
`default_nettype none
// ============================================================================
// nes_mem_pkg : shared widths and grant encoding for the NES memory arbiter
// Rev 1.0
// ============================================================================
package nes_mem_pkg;

    localparam int ADDR_W    = 22;
    localparam int SD_ADDR_W = 25;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_LD   = 2'd1,
        GNT_CPU  = 2'd2,
        GNT_PPU  = 2'd3
    } grant_e;

endpackage
`default_nettype wire

// File: rtl/nes_ce_gen.sv
`default_nettype none
// ============================================================================
// nes_ce_gen : free-running 4-phase counter producing run_nes and clkref
// Rev 1.0
// ============================================================================
module nes_ce_gen (
    input  logic clk,
    input  logic reset_n,
    output logic run_nes,
    output logic clkref
);

    localparam logic [1:0] PHASE_SLOT = 2'd3;

    logic [1:0] phase_q;
    logic [1:0] phase_d;

    always_comb begin
        phase_d = phase_q + 2'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            phase_q <= 2'd0;
        end else begin
            phase_q <= phase_d;
        end
    end

    always_comb begin
        run_nes = (phase_q == PHASE_SLOT);
        clkref  = phase_q[1];
    end

endmodule
`default_nettype wire

// File: rtl/nes_mem_arbiter.sv
`default_nettype none
// ============================================================================
// nes_mem_arbiter : slot-based SDRAM arbiter between ROM loader, CPU and PPU
// Rev 1.0
// ============================================================================
module nes_mem_arbiter #(
    parameter int ADDR_W    = nes_mem_pkg::ADDR_W,
    parameter int SD_ADDR_W = nes_mem_pkg::SD_ADDR_W
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 downloading,
    input  logic                 ld_wr,
    input  logic [ADDR_W-1:0]    ld_addr,
    input  logic [7:0]           ld_data,
    input  logic                 cpu_rd,
    input  logic                 cpu_wr,
    input  logic [ADDR_W-1:0]    cpu_addr,
    input  logic [7:0]           cpu_dout,
    input  logic                 ppu_rd,
    input  logic [ADDR_W-1:0]    ppu_addr,
    output logic                 run_nes,
    output logic                 clkref,
    output logic [SD_ADDR_W-1:0] mem_addr,
    output logic [7:0]           mem_din,
    output logic                 mem_we,
    output logic                 mem_oeA,
    output logic                 mem_oeB,
    output logic                 ppu_stall,
    output logic                 ld_overrun
);

    import nes_mem_pkg::*;

    logic                 slot_edge;
    logic                 drain;
    logic                 dl_rise;
    grant_e               grant;

    logic                 pending_q,   pending_d;
    logic [ADDR_W-1:0]    hold_addr_q, hold_addr_d;
    logic [7:0]           hold_data_q, hold_data_d;
    logic                 overrun_q,   overrun_d;
    logic                 dl_q,        dl_d;
    logic [SD_ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [7:0]           mem_din_q,   mem_din_d;
    logic                 mem_we_q,    mem_we_d;
    logic                 mem_oea_q,   mem_oea_d;
    logic                 mem_oeb_q,   mem_oeb_d;
    logic                 ppu_stall_q, ppu_stall_d;

    nes_ce_gen u_ce_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .run_nes (run_nes),
        .clkref  (clkref)
    );

    // run_nes is high during phase 3, so the next rising edge is the slot edge
    assign slot_edge = run_nes;

    // Loader holding register: a drain on this edge frees the slot for a new byte
    always_comb begin
        drain       = slot_edge && pending_q;
        dl_rise     = downloading && !dl_q;
        dl_d        = downloading;
        pending_d   = pending_q && !drain;
        hold_addr_d = hold_addr_q;
        hold_data_d = hold_data_q;
        overrun_d   = overrun_q && !dl_rise;
        if (ld_wr) begin
            if (!pending_q || drain) begin
                pending_d   = 1'b1;
                hold_addr_d = ld_addr;
                hold_data_d = ld_data;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_comb begin
        grant = GNT_NONE;
        if (pending_q) begin
            grant = GNT_LD;
        end else if (downloading) begin
            grant = GNT_NONE;
        end else if (cpu_rd || cpu_wr) begin
            grant = GNT_CPU;
        end else if (ppu_rd) begin
            grant = GNT_PPU;
        end

        mem_addr_d  = mem_addr_q;
        mem_din_d   = mem_din_q;
        mem_we_d    = mem_we_q;
        mem_oea_d   = mem_oea_q;
        mem_oeb_d   = mem_oeb_q;
        ppu_stall_d = ppu_stall_q;

        if (slot_edge) begin
            mem_we_d    = 1'b0;
            mem_oea_d   = 1'b0;
            mem_oeb_d   = 1'b0;
            ppu_stall_d = ppu_rd && (grant != GNT_PPU);
            case (grant)
                GNT_LD: begin
                    mem_we_d   = 1'b1;
                    mem_addr_d = SD_ADDR_W'(hold_addr_q);
                    mem_din_d  = hold_data_q;
                end
                GNT_CPU: begin
                    // rd+wr together is a write; keeps oeA exclusive of we
                    mem_we_d   = cpu_wr;
                    mem_oea_d  = !cpu_wr;
                    mem_addr_d = SD_ADDR_W'(cpu_addr);
                    mem_din_d  = cpu_dout;
                end
                GNT_PPU: begin
                    mem_oeb_d  = 1'b1;
                    mem_addr_d = SD_ADDR_W'(ppu_addr);
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pending_q   <= 1'b0;
            hold_addr_q <= '0;
            hold_data_q <= 8'd0;
            overrun_q   <= 1'b0;
            dl_q        <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= 8'd0;
            mem_we_q    <= 1'b0;
            mem_oea_q   <= 1'b0;
            mem_oeb_q   <= 1'b0;
            ppu_stall_q <= 1'b0;
        end else begin
            pending_q   <= pending_d;
            hold_addr_q <= hold_addr_d;
            hold_data_q <= hold_data_d;
            overrun_q   <= overrun_d;
            dl_q        <= dl_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
            mem_we_q    <= mem_we_d;
            mem_oea_q   <= mem_oea_d;
            mem_oeb_q   <= mem_oeb_d;
            ppu_stall_q <= ppu_stall_d;
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_din    = mem_din_q;
    assign mem_we     = mem_we_q;
    assign mem_oeA    = mem_oea_q;
    assign mem_oeB    = mem_oeb_q;
    assign ppu_stall  = ppu_stall_q;
    assign ld_overrun = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_nes_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_nes_mem_arbiter : directed vector table plus randomized reference-model run
// Rev 1.0
// ============================================================================
module tb_nes_mem_arbiter;

    localparam int AW = 22;
    localparam int SW = 25;

    logic          clk = 1'b0;
    logic          reset_n, downloading, ld_wr, cpu_rd, cpu_wr, ppu_rd;
    logic [AW-1:0] ld_addr, cpu_addr, ppu_addr;
    logic [7:0]    ld_data, cpu_dout;
    logic          run_nes, clkref, mem_we, mem_oeA, mem_oeB, ppu_stall, ld_overrun;
    logic [SW-1:0] mem_addr;
    logic [7:0]    mem_din;

    always #5 clk = ~clk;

    nes_mem_arbiter #(.ADDR_W(AW), .SD_ADDR_W(SW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .downloading (downloading),
        .ld_wr       (ld_wr),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .cpu_rd      (cpu_rd),
        .cpu_wr      (cpu_wr),
        .cpu_addr    (cpu_addr),
        .cpu_dout    (cpu_dout),
        .ppu_rd      (ppu_rd),
        .ppu_addr    (ppu_addr),
        .run_nes     (run_nes),
        .clkref      (clkref),
        .mem_addr    (mem_addr),
        .mem_din     (mem_din),
        .mem_we      (mem_we),
        .mem_oeA     (mem_oeA),
        .mem_oeB     (mem_oeB),
        .ppu_stall   (ppu_stall),
        .ld_overrun  (ld_overrun)
    );

    typedef struct packed {
        logic          run;
        logic          cref;
        logic          we;
        logic          oea;
        logic          oeb;
        logic [SW-1:0] addr;
        logic [7:0]    din;
        logic          stall;
        logic          ovr;
    } obs_t;

    typedef struct {
        logic          rn, dl, lw;
        logic [AW-1:0] la;
        logic [7:0]    ld;
        logic          cr, cw;
        logic [AW-1:0] ca;
        logic [7:0]    cd;
        logic          pr;
        logic [AW-1:0] pa;
        obs_t          exp;
    } vec_t;

    typedef struct {
        logic [AW-1:0] a;
        logic [7:0]    d;
    } ldrec_t;

    int     vectors     = 0;
    int     miscompares = 0;
    vec_t   tbl[$];

    // reference model: cycle count since reset, loader as a depth-1 queue
    int unsigned m_cyc = 0;
    ldrec_t      m_q[$];
    bit          m_ovr = 1'b0;
    bit          m_dl_prev = 1'b0;
    obs_t        m_out = '0;

    function automatic void add(input int rn, dl, lw, la, ld, cr, cw, ca, cd, pr, pa,
                                input int e_run, e_cref, e_we, e_oea, e_oeb, e_addr, e_din, e_st, e_ov);
        vec_t v;
        v.rn = 1'(rn);  v.dl = 1'(dl);  v.lw = 1'(lw);
        v.la = AW'(la); v.ld = 8'(ld);
        v.cr = 1'(cr);  v.cw = 1'(cw);
        v.ca = AW'(ca); v.cd = 8'(cd);
        v.pr = 1'(pr);  v.pa = AW'(pa);
        v.exp.run  = 1'(e_run);  v.exp.cref = 1'(e_cref);
        v.exp.we   = 1'(e_we);   v.exp.oea  = 1'(e_oea);  v.exp.oeb = 1'(e_oeb);
        v.exp.addr = SW'(e_addr); v.exp.din = 8'(e_din);
        v.exp.stall = 1'(e_st);  v.exp.ovr  = 1'(e_ov);
        tbl.push_back(v);
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.run = run_nes;  o.cref = clkref;  o.we = mem_we;  o.oea = mem_oeA;  o.oeb = mem_oeB;
        o.addr = mem_addr; o.din = mem_din; o.stall = ppu_stall; o.ovr = ld_overrun;
        return o;
    endfunction

    task automatic check(input string name, input obs_t got, input obs_t exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got run=%0b cref=%0b we=%0b oeA=%0b oeB=%0b addr=%h din=%h stall=%0b ovr=%0b | want run=%0b cref=%0b we=%0b oeA=%0b oeB=%0b addr=%h din=%h stall=%0b ovr=%0b",
                     name, got.run, got.cref, got.we, got.oea, got.oeb, got.addr, got.din, got.stall, got.ovr,
                     exp.run, exp.cref, exp.we, exp.oea, exp.oeb, exp.addr, exp.din, exp.stall, exp.ovr);
        end
    endtask

    // Advances the model by one rising edge using the inputs currently driven
    task automatic model_edge();
        bit     drop = 1'b0;
        bit     lost;
        ldrec_t r;
        if (!reset_n) begin
            m_cyc = 0;
            m_q.delete();
            m_ovr = 1'b0;
            m_dl_prev = 1'b0;
            m_out = '0;
            return;
        end
        if (m_cyc % 4 == 3) begin
            lost = ppu_rd;
            m_out.we = 1'b0; m_out.oea = 1'b0; m_out.oeb = 1'b0;
            if (m_q.size() != 0) begin
                r = m_q.pop_front();
                m_out.we = 1'b1; m_out.addr = SW'(r.a); m_out.din = r.d;
            end else if (downloading) begin
            end else if (cpu_rd || cpu_wr) begin
                m_out.we = cpu_wr; m_out.oea = !cpu_wr;
                m_out.addr = SW'(cpu_addr); m_out.din = cpu_dout;
            end else if (ppu_rd) begin
                m_out.oeb = 1'b1; m_out.addr = SW'(ppu_addr);
                lost = 1'b0;
            end
            m_out.stall = lost;
        end
        if (ld_wr) begin
            if (m_q.size() == 0) m_q.push_back('{ld_addr, ld_data});
            else drop = 1'b1;
        end
        if (downloading && !m_dl_prev) m_ovr = 1'b0;
        if (drop) m_ovr = 1'b1;
        m_dl_prev = downloading;
        m_cyc++;
        m_out.run  = (m_cyc % 4 == 3);
        m_out.cref = (m_cyc % 4 >= 2);
        m_out.ovr  = m_ovr;
    endtask

    task automatic tick(input string name, input bit use_exp, input obs_t exp);
        model_edge();
        @(posedge clk);
        #1;
        check({name, "/model"}, sample(), m_out);
        if (use_exp) check(name, sample(), exp);
    endtask

    task automatic apply(input vec_t v);
        reset_n = v.rn; downloading = v.dl; ld_wr = v.lw; ld_addr = v.la; ld_data = v.ld;
        cpu_rd = v.cr; cpu_wr = v.cw; cpu_addr = v.ca; cpu_dout = v.cd;
        ppu_rd = v.pr; ppu_addr = v.pa;
    endtask

    initial begin
        reset_n = 1'b0; downloading = 1'b0; ld_wr = 1'b0; ld_addr = '0; ld_data = 8'd0;
        cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_dout = 8'd0; ppu_rd = 1'b0; ppu_addr = '0;

        //  rn dl lw la     ld     cr cw ca      cd     pr pa         | run cref we oeA oeB addr       din    st ov
        // reset and idle phase pattern
        add(0,0,0,0,0,         0,0,0,0,         0,0,          0,0,0,0,0,0,0,0,0);
        add(1,0,0,0,0,         0,0,0,0,         0,0,          0,0,0,0,0,0,0,0,0);
        add(1,0,0,0,0,         0,0,0,0,         0,0,          0,1,0,0,0,0,0,0,0);
        add(1,0,0,0,0,         0,0,0,0,         0,0,          1,1,0,0,0,0,0,0,0);
        add(1,0,0,0,0,         0,0,0,0,         0,0,          0,0,0,0,0,0,0,0,0);
        // single loader byte drained at the next slot
        add(1,1,1,'h10,'hA5,   0,0,0,0,         0,0,          0,0,0,0,0,0,0,0,0);
        add(1,1,0,0,0,         0,0,0,0,         0,0,          0,1,0,0,0,0,0,0,0);
        add(1,1,0,0,0,         0,0,0,0,         0,0,          1,1,0,0,0,0,0,0,0);
        add(1,1,0,0,0,         0,0,0,0,         0,0,          0,0,1,0,0,'h10,'hA5,0,0);
        add(1,1,0,0,0,         0,0,0,0,         0,0,          0,0,1,0,0,'h10,'hA5,0,0);
        add(1,1,0,0,0,         0,0,0,0,         0,0,          0,1,1,0,0,'h10,'hA5,0,0);
        add(1,1,0,0,0,         0,0,0,0,         0,0,          1,1,1,0,0,'h10,'hA5,0,0);
        add(1,1,0,0,0,         0,0,0,0,         0,0,          0,0,0,0,0,'h10,'hA5,0,0);
        // second byte within one slot is dropped
        add(1,1,1,'h21,'h11,   0,0,0,0,         0,0,          0,0,0,0,0,'h10,'hA5,0,0);
        add(1,1,1,'h22,'h22,   0,0,0,0,         0,0,          0,1,0,0,0,'h10,'hA5,0,1);
        add(1,1,0,0,0,         0,0,0,0,         0,0,          1,1,0,0,0,'h10,'hA5,0,1);
        add(1,1,0,0,0,         0,0,0,0,         0,0,          0,0,1,0,0,'h21,'h11,0,1);
        add(1,1,0,0,0,         0,0,0,0,         0,0,          0,0,1,0,0,'h21,'h11,0,1);
        add(1,1,0,0,0,         0,0,0,0,         0,0,          0,1,1,0,0,'h21,'h11,0,1);
        add(1,1,0,0,0,         0,0,0,0,         0,0,          1,1,1,0,0,'h21,'h11,0,1);
        add(1,1,0,0,0,         0,0,0,0,         0,0,          0,0,0,0,0,'h21,'h11,0,1);
        // overrun cleared by downloading 0->1, then ld_wr on the drain edge
        add(1,0,1,'h30,'h33,   0,0,0,0,         0,0,          0,0,0,0,0,'h21,'h11,0,1);
        add(1,1,0,0,0,         0,0,0,0,         0,0,          0,1,0,0,0,'h21,'h11,0,0);
        add(1,1,0,0,0,         0,0,0,0,         0,0,          1,1,0,0,0,'h21,'h11,0,0);
        add(1,1,1,'h31,'h44,   0,0,0,0,         0,0,          0,0,1,0,0,'h30,'h33,0,0);
        add(1,1,0,0,0,         0,0,0,0,         0,0,          0,0,1,0,0,'h30,'h33,0,0);
        add(1,1,0,0,0,         0,0,0,0,         0,0,          0,1,1,0,0,'h30,'h33,0,0);
        add(1,1,0,0,0,         0,0,0,0,         0,0,          1,1,1,0,0,'h30,'h33,0,0);
        add(1,1,0,0,0,         0,0,0,0,         0,0,          0,0,1,0,0,'h31,'h44,0,0);
        // pending byte across downloading 1->0 beats CPU and PPU
        add(1,1,1,'h40,'h55,   0,0,0,0,         0,0,          0,0,1,0,0,'h31,'h44,0,0);
        add(1,0,0,0,0,         0,0,0,0,         0,0,          0,1,1,0,0,'h31,'h44,0,0);
        add(1,0,0,0,0,         1,0,'h8000,'h77, 1,'h200010,   1,1,1,0,0,'h31,'h44,0,0);
        add(1,0,0,0,0,         1,0,'h8000,'h77, 1,'h200010,   0,0,1,0,0,'h40,'h55,1,0);
        add(1,0,0,0,0,         1,0,'h8000,'h77, 1,'h200010,   0,0,1,0,0,'h40,'h55,1,0);
        add(1,0,0,0,0,         1,0,'h8000,'h77, 1,'h200010,   0,1,1,0,0,'h40,'h55,1,0);
        add(1,0,0,0,0,         1,0,'h8000,'h77, 1,'h200010,   1,1,1,0,0,'h40,'h55,1,0);
        add(1,0,0,0,0,         1,0,'h8000,'h77, 1,'h200010,   0,0,0,1,0,'h8000,'h77,1,0);
        add(1,0,0,0,0,         0,0,0,0,         1,'h200010,   0,0,0,1,0,'h8000,'h77,1,0);
        add(1,0,0,0,0,         0,0,0,0,         1,'h200010,   0,1,0,1,0,'h8000,'h77,1,0);
        add(1,0,0,0,0,         0,0,0,0,         1,'h200010,   1,1,0,1,0,'h8000,'h77,1,0);
        add(1,0,0,0,0,         0,0,0,0,         1,'h200010,   0,0,0,0,1,'h200010,'h77,0,0);
        // idle slot keeps address, then rd+wr together is a write
        add(1,0,0,0,0,         0,0,0,0,         0,0,          0,0,0,0,1,'h200010,'h77,0,0);
        add(1,0,0,0,0,         0,0,0,0,         0,0,          0,1,0,0,1,'h200010,'h77,0,0);
        add(1,0,0,0,0,         0,0,0,0,         0,0,          1,1,0,0,1,'h200010,'h77,0,0);
        add(1,0,0,0,0,         0,0,0,0,         0,0,          0,0,0,0,0,'h200010,'h77,0,0);
        add(1,0,0,0,0,         0,0,0,0,         0,0,          0,0,0,0,0,'h200010,'h77,0,0);
        add(1,0,0,0,0,         0,0,0,0,         0,0,          0,1,0,0,0,'h200010,'h77,0,0);
        add(1,0,0,0,0,         1,1,'h123,'hC3,  0,0,          1,1,0,0,0,'h200010,'h77,0,0);
        add(1,0,0,0,0,         1,1,'h123,'hC3,  0,0,          0,0,1,0,0,'h123,'hC3,0,0);
        // reset during an LD grant with a second byte pending
        add(1,1,1,'h50,'h66,   0,0,0,0,         0,0,          0,0,1,0,0,'h123,'hC3,0,0);
        add(1,1,0,0,0,         0,0,0,0,         0,0,          0,1,1,0,0,'h123,'hC3,0,0);
        add(1,1,0,0,0,         0,0,0,0,         0,0,          1,1,1,0,0,'h123,'hC3,0,0);
        add(1,1,1,'h51,'h77,   0,0,0,0,         0,0,          0,0,1,0,0,'h50,'h66,0,0);
        add(0,1,0,0,0,         0,0,0,0,         0,0,          0,0,0,0,0,0,0,0,0);
        add(1,0,0,0,0,         0,0,0,0,         0,0,          0,0,0,0,0,0,0,0,0);
        add(1,0,0,0,0,         0,0,0,0,         0,0,          0,1,0,0,0,0,0,0,0);
        add(1,0,0,0,0,         0,0,0,0,         0,0,          1,1,0,0,0,0,0,0,0);
        add(1,0,0,0,0,         0,0,0,0,         0,0,          0,0,0,0,0,0,0,0,0);
        add(1,0,0,0,0,         0,0,0,0,         0,0,          0,0,0,0,0,0,0,0,0);

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
            tick($sformatf("row%0d", i), 1'b1, tbl[i].exp);
        end

        // randomized traffic against the reference model
        for (int i = 0; i < 4000; i++) begin
            reset_n = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 39) == 0) downloading = ~downloading;
            ld_wr    = downloading ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
            ld_addr  = AW'($urandom);
            ld_data  = 8'($urandom);
            cpu_rd   = ($urandom_range(0, 2) == 0);
            cpu_wr   = ($urandom_range(0, 3) == 0);
            cpu_addr = AW'($urandom);
            cpu_dout = 8'($urandom);
            ppu_rd   = ($urandom_range(0, 1) == 0);
            ppu_addr = AW'($urandom);
            tick("rand", 1'b0, '0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nes_mem_arbiter.md
NES_MEM_ARBITER -- requirements
Module: nes_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 22, NES-side byte address width.
REQ-002 SHALL have parameter SD_ADDR_W, default 25, SDRAM controller address width. Upper bits are zero-filled.
REQ-003 clk  in  1  system clock (NES clock domain); all logic on rising edge.
REQ-004 reset_n  in  1  synchronous, active-low reset.
REQ-005 downloading  in  1  ROM download in progress.
REQ-006 ld_wr  in  1  loader byte-write strobe, one clk wide.
REQ-007 ld_addr  in  ADDR_W  loader byte address.
REQ-008 ld_data  in  8  loader byte data.
REQ-009 cpu_rd, cpu_wr  in  1 each  CPU access request, sampled at slot edge.
REQ-010 cpu_addr  in  ADDR_W  CPU address.
REQ-011 cpu_dout  in  8  CPU write data.
REQ-012 ppu_rd  in  1  PPU read request.
REQ-013 ppu_addr  in  ADDR_W  PPU address.
REQ-014 run_nes  out  1  NES clock enable.
REQ-015 clkref  out  1  SDRAM phase reference.
REQ-016 mem_addr  out  SD_ADDR_W, mem_din  out  8, mem_we  out  1, mem_oeA  out  1, mem_oeB  out  1  SDRAM controller port.
REQ-017 ppu_stall  out  1  PPU request lost arbitration this slot.
REQ-018 ld_overrun  out  1  sticky: a loader byte was dropped.

Function
REQ-019 SHALL run a free-running 2-bit phase counter that increments every clk.
REQ-020 run_nes SHALL be 1 exactly when phase==3; clkref SHALL equal phase[1].
REQ-021 Loader holding register: ld_wr with no pending entry SHALL capture ld_addr/ld_data and set pending.
REQ-022 ld_wr while pending, with no drain in the same cycle, SHALL drop the new byte, keep the held byte, and set ld_overrun.
REQ-023 Slot edge = rising edge where phase==3. All mem_* outputs and ppu_stall SHALL be registered, update only at slot edges, and hold for 4 clks.
REQ-024 Grant selection at each slot edge, highest priority first:
- LD if pending: mem_we=1, mem_addr={0,held addr}, mem_din=held data, pending cleared.
- NONE if downloading=1 and no pending entry: all strobes 0.
- CPU if cpu_rd|cpu_wr: mem_addr={0,cpu_addr}, mem_we=cpu_wr, mem_oeA=cpu_rd, mem_din=cpu_dout.
- PPU if ppu_rd: mem_addr={0,ppu_addr}, mem_oeB=1.
- otherwise NONE: strobes 0, mem_addr held.
REQ-025 mem_we and mem_oeA SHALL never both be 1. mem_oeA and mem_oeB SHALL never both be 1.
REQ-026 ppu_stall SHALL be 1 for the slot when ppu_rd=1 at the slot edge but the grant is not PPU.
REQ-027 ld_wr on the same edge as a drain SHALL capture the new byte, leave pending=1, and not set ld_overrun.
REQ-028 A pending entry at the downloading 1->0 transition SHALL still be drained before any CPU/PPU grant.
REQ-029 ld_overrun SHALL clear only on reset or on the downloading 0->1 edge.
REQ-030 cpu_rd and cpu_wr both asserted SHALL be treated as a write.

Reset
REQ-031 reset_n=0 SHALL set phase=0, pending=0, ld_overrun=0, ppu_stall=0, mem_we=mem_oeA=mem_oeB=0, mem_addr=0, mem_din=0, grant=NONE.
REQ-032 Reset mid-slot SHALL abort the current grant immediately; the first slot edge after release SHALL occur 3 clks after reset_n rises.

Structure
REQ-033 Package nes_mem_pkg SHALL hold ADDR_W, SD_ADDR_W and the grant enum {GNT_NONE, GNT_LD, GNT_CPU, GNT_PPU}.
REQ-034 The phase counter plus run_nes/clkref generation SHALL be the single sub-module nes_ce_gen.

Verification
REQ-035 Reset release, idle inputs -> run_nes pulses every 4th clk, first at clk 3. clkref pattern 0,0,1,1. All mem strobes 0.
REQ-036 downloading=1, ld_wr addr 0x000010 data 0xA5 at phase 0 -> at next slot edge mem_we=1, mem_addr=0x0000010, mem_din=0xA5 for 4 clks; pending clears.
REQ-037 Two ld_wr 1 clk apart within one slot -> second byte dropped, ld_overrun=1. A following drain writes the first byte.
REQ-038 downloading=0, cpu_rd addr 0x008000 and ppu_rd addr 0x200010 together -> mem_oeA=1, mem_addr=0x0008000, ppu_stall=1. Next slot with ppu_rd only -> mem_oeB=1, mem_addr=0x0200010.
REQ-039 ld_wr at the drain edge while pending -> old byte written, new byte written next slot, ld_overrun stays 0.
REQ-040 reset_n=0 during an LD grant -> mem_we=0 next clk, pending=0. After release no stale write occurs.
